// File: rtl/hft_arb_pkg.sv
// Shared types and constants for the engine command-source arbiter.
// Sources are UDP frame parser and UART command decoder.
package hft_arb_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        BURST_UDP   = 3'd1,
        BURST_UART  = 3'd2,
        ABORT_PAD   = 3'd3,
        DUMP_ARM    = 3'd4,
        DUMP_STREAM = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_UDP  = 2'b01,
        SRC_UART = 2'b10
    } src_t;

    // Zero-quantity no-op word, used to close an abandoned batch on the engine side.
    localparam logic [31:0] PAD_WORD = 32'h0000_0000;
    localparam logic [23:0] OP_DUMP  = 24'hF0E0D0;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a registered last-grant pointer.
// Bit 0 is UDP, bit 1 is UART; after reset the pointer favours bit 0.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic [1:0] last_grant_reg;
    logic [1:0] last_grant_next;

    // A requester wins when alone, or on a tie when the other one won last time.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
            assign gnt[gi] = en & req[gi] & (~req[1-gi] | last_grant_reg[1-gi]);
        end
    endgenerate

    always_comb begin
        last_grant_next = last_grant_reg;
        if (|gnt) begin
            last_grant_next = gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_reg <= 2'b10;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end

endmodule

// File: rtl/cmd_source_arbiter.sv
// Shares the matching-engine command input between the UDP and UART sources,
// keeping UDP batches atomic and routing dump responses back to the requester.
module cmd_source_arbiter
    import hft_arb_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int BURST_TIMEOUT = 256,
    parameter int ABORT_CNT_W   = 8
) (
    input  logic                   clk_engine,
    input  logic                   rst_engine_n,
    input  logic [DATA_W-1:0]      udp_cmd_tdata,
    input  logic                   udp_cmd_tvalid,
    input  logic                   udp_cmd_tlast,
    input  logic                   udp_cmd_tdump,
    output logic                   udp_cmd_tready,
    input  logic [DATA_W-1:0]      uart_cmd_tdata,
    input  logic                   uart_cmd_tvalid,
    input  logic                   uart_cmd_tlast,
    input  logic                   uart_cmd_tdump,
    output logic                   uart_cmd_tready,
    output logic [DATA_W-1:0]      eng_tdata,
    output logic                   eng_tvalid,
    output logic                   eng_tlast,
    input  logic                   eng_tready,
    input  logic                   eng_busy,
    output logic                   eng_dump_start,
    input  logic [DATA_W-1:0]      dump_tdata,
    input  logic                   dump_tvalid,
    input  logic                   dump_tlast,
    output logic                   dump_tready,
    output logic [DATA_W-1:0]      udp_rsp_tdata,
    output logic                   udp_rsp_tvalid,
    output logic                   udp_rsp_tlast,
    input  logic                   udp_rsp_tready,
    output logic [DATA_W-1:0]      uart_rsp_tdata,
    output logic                   uart_rsp_tvalid,
    output logic                   uart_rsp_tlast,
    input  logic                   uart_rsp_tready,
    output logic [1:0]             grant_owner,
    output logic [ABORT_CNT_W-1:0] abort_cnt,
    output logic                   proto_err
);

    localparam int IDLE_W = $clog2(BURST_TIMEOUT);

    state_t                  state_reg, state_next;
    src_t                    owner_reg, owner_next;
    logic [IDLE_W-1:0]       idle_cnt_reg, idle_cnt_next;
    logic [ABORT_CNT_W-1:0]  abort_cnt_reg, abort_cnt_next;
    logic                    proto_err_reg, proto_err_next;
    logic                    first_beat_reg, first_beat_next;

    logic [1:0]              gnt;
    logic [DATA_W-1:0]       sel_tdata;
    logic                    sel_tvalid, sel_tlast, sel_tdump;
    logic                    src_tready;
    logic                    rsp_tvalid_own;

    rr_arbiter2 u_rr (
        .clk   (clk_engine),
        .rst_n (rst_engine_n),
        .req   ({uart_cmd_tvalid, udp_cmd_tvalid}),
        .en    (state_reg == IDLE),
        .gnt   (gnt)
    );

    // Owner-selected view of the command sources.
    always_comb begin
        sel_tdata  = udp_cmd_tdata;
        sel_tvalid = udp_cmd_tvalid;
        sel_tlast  = udp_cmd_tlast;
        sel_tdump  = udp_cmd_tdump;
        if (owner_reg == SRC_UART) begin
            sel_tdata  = uart_cmd_tdata;
            sel_tvalid = uart_cmd_tvalid;
            sel_tlast  = uart_cmd_tlast;
            sel_tdump  = uart_cmd_tdump;
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        idle_cnt_next   = idle_cnt_reg;
        abort_cnt_next  = abort_cnt_reg;
        proto_err_next  = proto_err_reg;
        first_beat_next = first_beat_reg;
        eng_tdata       = sel_tdata;
        eng_tvalid      = 1'b0;
        eng_tlast       = 1'b0;
        eng_dump_start  = 1'b0;
        src_tready      = 1'b0;
        dump_tready     = 1'b0;
        rsp_tvalid_own  = 1'b0;

        case (state_reg)
            IDLE: begin
                idle_cnt_next   = '0;
                first_beat_next = 1'b1;
                if (gnt[0]) begin
                    owner_next = SRC_UDP;
                    state_next = udp_cmd_tdump ? DUMP_ARM : BURST_UDP;
                end else if (gnt[1]) begin
                    owner_next = SRC_UART;
                    state_next = uart_cmd_tdump ? DUMP_ARM : BURST_UART;
                end
            end

            BURST_UDP, BURST_UART: begin
                if (sel_tvalid && sel_tdump && !first_beat_reg) begin
                    // Stray dump mid-batch: swallow it so the batch can finish.
                    src_tready     = 1'b1;
                    proto_err_next = 1'b1;
                    idle_cnt_next  = '0;
                end else begin
                    eng_tvalid = sel_tvalid;
                    eng_tlast  = sel_tlast;
                    src_tready = eng_tready;
                    if (sel_tvalid && eng_tready) begin
                        idle_cnt_next   = '0;
                        first_beat_next = 1'b0;
                        if (sel_tlast) begin
                            state_next = IDLE;
                            owner_next = SRC_NONE;
                        end
                    end else if (!sel_tvalid) begin
                        idle_cnt_next = idle_cnt_reg + 1'b1;
                        if (idle_cnt_reg == IDLE_W'(BURST_TIMEOUT - 2)) begin
                            state_next = ABORT_PAD;
                        end
                    end
                end
            end

            ABORT_PAD: begin
                eng_tdata  = DATA_W'(PAD_WORD);
                eng_tvalid = 1'b1;
                eng_tlast  = 1'b1;
                if (eng_tready) begin
                    state_next = IDLE;
                    owner_next = SRC_NONE;
                    if (!(&abort_cnt_reg)) begin
                        abort_cnt_next = abort_cnt_reg + 1'b1;
                    end
                end
            end

            DUMP_ARM: begin
                if (!eng_busy) begin
                    eng_dump_start = 1'b1;
                    src_tready     = 1'b1;
                    state_next     = DUMP_STREAM;
                end
            end

            DUMP_STREAM: begin
                rsp_tvalid_own = dump_tvalid;
                dump_tready    = (owner_reg == SRC_UART) ? uart_rsp_tready : udp_rsp_tready;
                if (dump_tvalid && dump_tready && dump_tlast) begin
                    state_next = IDLE;
                    owner_next = SRC_NONE;
                end
            end

            default: begin
                state_next = IDLE;
                owner_next = SRC_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_engine) begin
        if (!rst_engine_n) begin
            state_reg      <= IDLE;
            owner_reg      <= SRC_NONE;
            idle_cnt_reg   <= '0;
            abort_cnt_reg  <= '0;
            proto_err_reg  <= 1'b0;
            first_beat_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            idle_cnt_reg   <= idle_cnt_next;
            abort_cnt_reg  <= abort_cnt_next;
            proto_err_reg  <= proto_err_next;
            first_beat_reg <= first_beat_next;
        end
    end

    assign udp_cmd_tready  = src_tready && (owner_reg == SRC_UDP);
    assign uart_cmd_tready = src_tready && (owner_reg == SRC_UART);

    assign udp_rsp_tdata   = dump_tdata;
    assign udp_rsp_tlast   = dump_tlast;
    assign udp_rsp_tvalid  = rsp_tvalid_own && (owner_reg == SRC_UDP);
    assign uart_rsp_tdata  = dump_tdata;
    assign uart_rsp_tlast  = dump_tlast;
    assign uart_rsp_tvalid = rsp_tvalid_own && (owner_reg == SRC_UART);

    assign grant_owner = owner_reg;
    assign abort_cnt   = abort_cnt_reg;
    assign proto_err   = proto_err_reg;

endmodule

// File: doc/cmd_source_arbiter.md
Name: cmd_source_arbiter

Overview:
Shares the single matching-engine command input between two requesters: the UDP frame parser (order batches and the F0E0D0 dump opcode) and the UART command decoder (the F0 E0 D0 dump trigger).
- Keeps each UDP order batch atomic on the engine input.
- Sequences dump requests into the engine.
- Routes the engine's dump response stream back to whichever source requested it.
- Sits in the clk_engine domain, after the CDC FIFOs, ahead of the order book.

Parameters:
DATA_W, 32, command/response word width ({price[31:16], is_buy[15], is_bot[14], qty[13:0]})
BURST_TIMEOUT, 256, idle cycles inside a granted burst before abort
ABORT_CNT_W, 8, width of saturating abort counter

Ports:
clk_engine  in  1  engine clock; all logic on rising edge
rst_engine_n  in  1  synchronous reset, active-low
udp_cmd_tdata  in  DATA_W  UDP-source command word
udp_cmd_tvalid  in  1  UDP word valid
udp_cmd_tlast  in  1  last word of UDP batch
udp_cmd_tdump  in  1  word is a dump request (single beat)
udp_cmd_tready  out  1  UDP word accepted
uart_cmd_tdata / _tvalid / _tlast / _tdump  in  DATA_W/1/1/1  UART-source equivalents
uart_cmd_tready  out  1  UART word accepted
eng_tdata  out  DATA_W  command word to engine
eng_tvalid  out  1  engine word valid
eng_tlast  out  1  end of batch
eng_tready  in  1  engine accepts word
eng_busy  in  1  engine processing; dump must not start while high
eng_dump_start  out  1  one-cycle dump trigger
dump_tdata / dump_tvalid / dump_tlast  in  DATA_W/1/1  engine dump response stream
dump_tready  out  1  response accepted by the owning sink
udp_rsp_tdata / _tvalid / _tlast  out  DATA_W/1/1  response to UDP tx path
udp_rsp_tready  in  1  UDP tx ready
uart_rsp_tdata / _tvalid / _tlast  out  DATA_W/1/1  response to UART tx path
uart_rsp_tready  in  1  UART tx ready
grant_owner  out  2  00 none, 01 UDP, 10 UART
abort_cnt  out  ABORT_CNT_W  saturating count of timed-out bursts
proto_err  out  1  sticky flag: tdump seen on a non-first burst beat

Behaviour:
Reset values (rst_engine_n low at an edge):
- state=IDLE, last_grant=UART (so UDP wins the first tie).
- All tready/tvalid outputs 0, eng_dump_start 0, grant_owner 00, abort_cnt 0, proto_err 0, idle counter 0.

IDLE:
- Requests are each source's tvalid.
- Arbitration: 2-way round-robin; on a tie, grant the source not granted last. last_grant updates on every grant.
- Granted head word with tdump=0 -> BURST_x.
- Granted head word with tdump=1 -> DUMP_ARM.
- Latency: grant is registered; the first transfer occurs no earlier than the cycle after tvalid is first seen.

BURST_x:
- Combinational pass-through: eng_tdata/tvalid/tlast = source x; x_cmd_tready = eng_tready.
- The other source's tready is 0.
- Exit on eng_tvalid & eng_tready & eng_tlast -> IDLE.
- tdump=1 on a non-first beat: word consumed (tready=1), not forwarded, proto_err set; the burst continues.
- Idle counter: increments on each cycle with source tvalid low; clears on any transfer.
- Counter reaching BURST_TIMEOUT-1 -> ABORT_PAD.

ABORT_PAD:
- Drive eng_tdata=0x00000000 (qty 0, no-op), eng_tvalid=1, eng_tlast=1.
- Source tready 0.
- On eng_tready -> IDLE; abort_cnt increments, saturating at all-ones.

DUMP_ARM:
- Wait while eng_busy=1.
- With eng_busy=0: in one cycle, pulse eng_dump_start, assert x_cmd_tready to consume the dump beat, latch owner=x -> DUMP_STREAM.
- The dump beat is never forwarded on eng_*.

DUMP_STREAM:
- Owner rsp_* = dump_*; dump_tready = owner rsp_tready.
- Non-owner rsp_tvalid 0. Both cmd readies 0; new requests wait.
- Exit on dump_tvalid & dump_tready & dump_tlast -> IDLE.
- dump_tvalid while not in DUMP_STREAM: dump_tready 0, stream stalls.

Status and reset:
- grant_owner reflects the current owner in BURST/ABORT_PAD/DUMP_*; 00 in IDLE.
- Reset mid-operation returns to IDLE at that edge: no pad emitted, remaining dump response left stalled (dump_tready 0).

Decomposition:
- Package hft_arb_pkg holds:
  - state enum: IDLE, BURST_UDP, BURST_UART, ABORT_PAD, DUMP_ARM, DUMP_STREAM
  - source IDs: SRC_NONE, SRC_UDP, SRC_UART
  - PAD_WORD = 32'h0
  - OP_DUMP = 24'hF0E0D0
- One sub-module: rr_arbiter2 (two requests, enable, registered last_grant, one-hot grant).

Test Plan:
- UDP batch {105/sell/10, 100/sell/20} with UART idle -> two eng words in order, eng_tlast on second, grant_owner 01 during burst, 00 after.
- UDP and UART assert tvalid in the same cycle after reset -> UDP granted first; next tie -> UART granted.
- UART dump word with eng_busy=1 for 20 cycles -> eng_dump_start pulses exactly once, in the cycle after eng_busy falls; 8-word dump routed only to uart_rsp_*; udp_rsp_tvalid stays 0.
- UDP starts a 3-word batch, then tvalid held low for 300 cycles -> at idle count 255, pad word 0x00000000 with eng_tlast=1; abort_cnt=1; then IDLE.
- Dump stream with uart_rsp_tready toggling every cycle -> every word delivered once, no drops or duplicates; a UDP request during the stream is held off until dump_tlast completes.
- rst_engine_n low for one cycle mid-burst -> next cycle all tready/tvalid 0, state IDLE, abort_cnt 0.
